// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the four-master bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned NUM_MASTERS      = 4;
  localparam int unsigned MASTER_W         = 2;
  localparam int unsigned BUS_SLAVE_ADDR   = 3;
  localparam int unsigned MAX_HOLD_DEFAULT = 16;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    REVOKE = 2'd2
  } arb_state_t;

  // One-hot grant vector for a master index.
  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MASTER_W-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = ENABLE;
    return v;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin picker: first requester after last_owner, wrapping 3 -> 0,
// so last_owner itself is considered last.
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MASTER_W-1:0]    last_owner,
  output logic [MASTER_W-1:0]    pick,
  output logic                   valid
);

  logic [MASTER_W-1:0] idx;

  // Scan from last_owner+1 upward; the first hit wins.
  always_comb begin
    pick  = last_owner;
    valid = DISABLE;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = last_owner + MASTER_W'(i);
      if (!valid && req[idx]) begin
        pick  = idx;
        valid = ENABLE;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with hold-time limit and forced
// one-cycle release when another master is waiting.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_req,
  input  logic                      m1_req,
  input  logic                      m2_req,
  input  logic                      m3_req,
  input  logic [31:0]               m0_addr,
  input  logic [31:0]               m1_addr,
  input  logic [31:0]               m2_addr,
  input  logic [31:0]               m3_addr,
  output logic                      m0_grnt,
  output logic                      m1_grnt,
  output logic                      m2_grnt,
  output logic                      m3_grnt,
  output logic [1:0]                owner,
  output logic                      bus_busy,
  output logic [BUS_SLAVE_ADDR-1:0] s_addr
);

  localparam int unsigned      CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  arb_state_t                state, state_nx;
  logic [NUM_MASTERS-1:0]    req, grant, grant_nx;
  logic [MASTER_W-1:0]       owner_q, owner_nx, pick;
  logic                      pick_valid;
  logic [CNT_W-1:0]          hold_cnt, hold_cnt_nx;
  logic                      others_req, revoke, decide;
  logic [BUS_SLAVE_ADDR-1:0] addr_sel;
  logic                      addr_unused;

  assign req = {m3_req, m2_req, m1_req, m0_req};

  bus_rr_pick u_pick (
    .req        (req),
    .last_owner (owner_q),
    .pick       (pick),
    .valid      (pick_valid)
  );

  // Revoke when the hold limit is reached and someone else is waiting.
  always_comb begin
    others_req = |(req & ~onehot(owner_q));
    revoke     = (hold_cnt == HOLD_MAX) && req[owner_q] && others_req;
  end

  // Next-state logic; IDLE, REVOKE and an owner release all share one
  // round-robin decision so a handover never leaves an idle gap.
  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    owner_nx    = owner_q;
    hold_cnt_nx = hold_cnt;
    decide      = DISABLE;
    case (state)
      GRANT: begin
        if (!req[owner_q]) begin
          decide = ENABLE;
        end else if (revoke) begin
          state_nx    = REVOKE;
          grant_nx    = '0;
          hold_cnt_nx = '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_nx = hold_cnt + CNT_W'(1);
        end
      end
      default: decide = ENABLE;
    endcase
    if (decide) begin
      if (pick_valid) begin
        state_nx    = GRANT;
        grant_nx    = onehot(pick);
        owner_nx    = pick;
        hold_cnt_nx = CNT_W'(1);
      end else begin
        state_nx    = IDLE;
        grant_nx    = '0;
        hold_cnt_nx = '0;
      end
    end
  end

  // State, grant, owner and hold counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner_q  <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      owner_q  <= owner_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  // Slave index from the owner's address; forced to zero with no grant.
  always_comb begin
    case (owner_q)
      2'd0:    addr_sel = m0_addr[31:29];
      2'd1:    addr_sel = m1_addr[31:29];
      2'd2:    addr_sel = m2_addr[31:29];
      default: addr_sel = m3_addr[31:29];
    endcase
    s_addr = (|grant) ? addr_sel : '0;
  end

  // Low address bits are decoded downstream, not by the arbiter.
  assign addr_unused = ^{m0_addr[28:0], m1_addr[28:0], m2_addr[28:0], m3_addr[28:0]};

  assign m0_grnt  = grant[0];
  assign m1_grnt  = grant[1];
  assign m2_grnt  = grant[2];
  assign m3_grnt  = grant[3];
  assign owner    = owner_q;
  assign bus_busy = |grant;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, giving the grant cycles after which a held grant is revoked if another master is waiting.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports m0_req..m3_req, input, 1 each, bus request from masters 0..3.
REQ-005 SHALL have ports m0_addr..m3_addr, input, 32 each, byte address from masters 0..3.
REQ-006 SHALL have ports m0_grnt..m3_grnt, output, 1 each, registered bus grant; at most one high.
REQ-007 SHALL have port owner, output, 2, index of the current or last-granted master.
REQ-008 SHALL have port bus_busy, output, 1, high when any grant is high.
REQ-009 SHALL have port s_addr, output, `BUS_SLAVE_ADDR (3), slave index = bits [31:29] of the granted master's address; feeds the address decoder.

Function
REQ-010 SHALL implement states IDLE (no grant), GRANT (one master granted) and REVOKE (forced one-cycle release).
REQ-011 IDLE: if any req high, SHALL grant the first requester in round-robin order from owner+1 (mod 4) in the next cycle and enter GRANT; otherwise SHALL stay in IDLE.
REQ-012 GRANT: while owner's req stays high and no revoke condition holds, SHALL keep the same grant.
REQ-013 GRANT: when owner's req drops, SHALL hand over in the next cycle to the next requester after owner (round-robin), or enter IDLE if none; no idle gap on handover.
REQ-014 SHALL count grant cycles from 1 in the first cycle of each grant, saturating at MAX_HOLD, and reload on every new grant.
REQ-015 Revoke condition: count == MAX_HOLD, owner's req high, and another req high; SHALL then deassert all grants in the next cycle (REVOKE).
REQ-016 REVOKE: SHALL last exactly one cycle, then grant the next requester after owner (round-robin) and never the revoked owner if any other master requests.
REQ-017 Round-robin SHALL wrap 3 -> 0; the revoked or releasing owner has lowest priority for the next decision.
REQ-018 Simultaneous owner release and new requests SHALL be resolved in the same decision cycle, with the current-cycle req values sampled.
REQ-019 A single requester SHALL be regranted after REVOKE only when no other master requests.
REQ-020 A request dropped before its grant SHALL simply be skipped; grants SHALL never go to a master whose req was low in the decision cycle.
REQ-021 s_addr SHALL be combinational from the granted master's address (owner select); it SHALL hold 3'b000 when no grant is high.
REQ-022 bus_busy SHALL equal the OR of the four grants.

Reset
REQ-023 On reset: state IDLE, all grants 0, owner 2'd3 (so master 0 wins first), hold counter 0, bus_busy 0, s_addr 0.
REQ-024 Reset asserted mid-grant SHALL clear grants immediately (asynchronous); after release the first decision SHALL follow REQ-011 from owner 3.

Structure
REQ-025 State encodings, master count and MAX_HOLD default SHALL live in global.v alongside the `BUS_SLAVE_ADDR, `ENABLE and `DISABLE macros.
REQ-026 SHALL contain one sub-module, bus_rr_pick (4 requests + last owner -> next index + valid), used by both the IDLE/GRANT handover and the REVOKE paths.

Verification
REQ-027 After reset, m0_req=m2_req=1 at the same cycle -> m0_grnt=1 next cycle, owner=0; m0_req drops -> m2_grnt=1 next cycle with no gap.
REQ-028 m1_req held, m3_req raised, MAX_HOLD=16 -> m1 granted 16 cycles, 1 cycle all grants 0, then m3_grnt=1, owner=3.
REQ-029 Only m2_req held 40 cycles -> m2_grnt stays 1 throughout; no REVOKE.
REQ-030 m0 granted with m0_addr=32'hA000_0000 -> s_addr=3'b101; after release to IDLE -> s_addr=3'b000, bus_busy=0.
REQ-031 All four reqs held, each releases after 2 cycles and re-requests -> grant order 0,1,2,3,0 (wrap).
REQ-032 reset asserted asynchronously while m1 is granted -> m1_grnt=0 before the next clk edge; after release m1_req and m0_req both high -> m0 granted.
